// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg: shared widths, types and the sample saturation helper.
// ---------------------------------------------------------------------------
`default_nettype none

package synth_pkg;

    localparam int NUM_VOICES = 8;
    localparam int FRAME_LEN  = 16;
    localparam int PHASE_W    = 48;
    localparam int SAMPLE_W   = 16;
    localparam int VOL_SHIFT  = 6;
    localparam int FRAC_BITS  = 20;
    localparam int MIX_W      = 24;
    localparam int FILT_W     = SAMPLE_W + 2;
    localparam int CNT_W      = $clog2(FRAME_LEN);

    typedef logic        [PHASE_W-1:0]  phase_t;
    typedef logic signed [MIX_W-1:0]    mix_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [FILT_W-1:0]   filt_t;

    localparam mix_t SAMPLE_MAX = mix_t'((1 << (SAMPLE_W - 1)) - 1);
    localparam mix_t SAMPLE_MIN = mix_t'(-(1 << (SAMPLE_W - 1)));

    function automatic sample_t saturate(input mix_t value);
        sample_t result;
        if (value > SAMPLE_MAX) begin
            result = sample_t'(SAMPLE_MAX);
        end else if (value < SAMPLE_MIN) begin
            result = sample_t'(SAMPLE_MIN);
        end else begin
            result = sample_t'(value);
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/synth_voice.sv
// ---------------------------------------------------------------------------
// synth_voice: one square-wave voice (phase accumulator + signed gain).
// ---------------------------------------------------------------------------
`default_nettype none

module synth_voice
    import synth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [31:0] frequency,
    input  phase_t      p,
    input  logic [31:0] volume,
    output mix_t        contribution
);

    localparam logic [31:0] MAG_MAX = 32'((1 << (MIX_W - 1)) - 1);

    phase_t               acc;
    phase_t               acc_next;
    logic [PHASE_W:0]     sum;
    logic [PHASE_W+1:0]   p_times3;
    logic [31:0]          scaled;
    logic [MIX_W-1:0]     magnitude;
    logic                 positive;

    // Contribution reflects the post-advance phase so the top can latch it on the tick edge.
    always_comb begin
        sum      = {1'b0, acc} + {{(PHASE_W - 31){1'b0}}, frequency};
        acc_next = sum[PHASE_W-1:0];
        if (sum >= {1'b0, p}) begin
            acc_next = phase_t'(sum - {1'b0, p});
        end
        positive  = (acc_next < (p >> 1));
        p_times3  = {2'b00, p} + {1'b0, p, 1'b0};
        scaled    = volume >> VOL_SHIFT;
        magnitude = (scaled > MAG_MAX) ? MAG_MAX[MIX_W-1:0] : scaled[MIX_W-1:0];
        contribution = positive ? $signed(magnitude) : -$signed(magnitude);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= p_times3[PHASE_W+1:2];
        end else if (tick) begin
            acc <= acc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/square_synthesizer.sv
// ---------------------------------------------------------------------------
// square_synthesizer: 8-voice square mixer with optional one-pole low-pass.
// ---------------------------------------------------------------------------
`default_nettype none

module square_synthesizer
    import synth_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                clock_speed_divided_by_16,
    input  logic                       filter_enabled,
    input  logic [2:0]                 cutoff,
    input  logic [31:0]                voice_volumes [NUM_VOICES-1:0],
    input  logic [31:0]                frequencies   [NUM_VOICES-1:0],
    output logic signed [SAMPLE_W-1:0] out
);

    logic [CNT_W-1:0] frame_count;
    logic             tick;
    phase_t           p;
    mix_t             contributions [NUM_VOICES-1:0];
    mix_t             mix_sum;
    sample_t          mix;
    filt_t            y;
    filt_t            y_next;
    filt_t            diff;

    assign tick = (frame_count == CNT_W'(FRAME_LEN - 1));
    assign p    = phase_t'(clock_speed_divided_by_16) << FRAC_BITS;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        synth_voice u_voice (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .frequency    (frequencies[i]),
            .p            (p),
            .volume       (voice_volumes[i]),
            .contribution (contributions[i])
        );
    end

    // y and the mix both stay within the sample range, so the two guard bits never overflow.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_sum = mix_sum + contributions[i];
        end
        mix    = saturate(mix_sum);
        diff   = filt_t'(mix) - y;
        y_next = y + (diff >>> cutoff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
            y           <= '0;
            out         <= '0;
        end else begin
            frame_count <= tick ? '0 : frame_count + 1'b1;
            if (tick) begin
                y   <= y_next;
                out <= filter_enabled ? sample_t'(y_next) : mix;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_square_synthesizer.sv
// ---------------------------------------------------------------------------
// tb_square_synthesizer: scoreboard bench for square_synthesizer.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_square_synthesizer;
    import synth_pkg::*;

    localparam int          SPEED     = 96000;
    // Frequencies x4 and steps /4 keep the per-step phase advance of 55/110 Hz over 6976 clocks.
    localparam int          STEP_CLKS = 1744;
    localparam logic [31:0] F_LO      = 32'd220 << 20;
    localparam logic [31:0] F_HI      = 32'd440 << 20;
    localparam logic [31:0] F_PRE     = 32'd4000 << 20;
    localparam logic [31:0] VOL_FULL  = 32'd1 << 20;
    localparam logic [31:0] VOL_HALF  = 32'd1 << 19;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [31:0]                clock_speed;
    logic                       filter_enabled;
    logic [2:0]                 cutoff;
    logic [31:0]                vols  [NUM_VOICES-1:0];
    logic [31:0]                freqs [NUM_VOICES-1:0];
    logic signed [SAMPLE_W-1:0] out;

    int compared   = 0;
    int mismatched = 0;
    int expected_q [$];
    int seq [8];
    int last_exp;
    int y_model;

    square_synthesizer dut (
        .clk                       (clk),
        .reset                     (reset),
        .clock_speed_divided_by_16 (clock_speed),
        .filter_enabled            (filter_enabled),
        .cutoff                    (cutoff),
        .voice_volumes             (vols),
        .frequencies               (freqs),
        .out                       (out)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_out", int'(out), 0);
        reset = 1'b0;
    endtask

    task automatic queue_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) expected_q.push_back(seq[i]);
        for (int i = 0; i < n; i++) begin
            repeat (STEP_CLKS) @(posedge clk);
            @(negedge clk);
            check_value($sformatf("%s[%0d]", tag, i), int'(out), expected_q.pop_front());
        end
    endtask

    task automatic filter_tick(input string tag);
        repeat (FRAME_LEN / 2) @(posedge clk);
        @(negedge clk);
        check_value({tag, "_hold"}, int'(out), last_exp);
        repeat (FRAME_LEN / 2) @(posedge clk);
        @(negedge clk);
        last_exp = expected_q.pop_front();
        check_value(tag, int'(out), last_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        clock_speed    = SPEED;
        filter_enabled = 1'b0;
        cutoff         = 3'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            vols[i]  = '0;
            freqs[i] = F_LO;
        end
        vols[0] = VOL_FULL;
        do_reset();

        seq = '{-16384, 16384, 16384, -16384, -16384, 16384, 0, 0};
        queue_steps("single", 6);

        freqs[0] = F_HI;
        seq = '{-16384, 16384, -16384, 16384, -16384, 16384, 0, 0};
        queue_steps("switch", 6);

        freqs[0] = F_LO;
        seq = '{16384, -16384, -16384, 16384, 16384, -16384, -16384, 0};
        queue_steps("back", 7);

        vols[0]  = '0;
        freqs[1] = F_HI;
        vols[1]  = VOL_HALF;
        seq = '{-8192, 8192, 0, 0, 0, 0, 0, 0};
        queue_steps("mix_v1", 2);

        vols[0] = VOL_HALF;
        seq = '{-16384, 0, 0, 16384, -16384, 0, 0, 16384};
        queue_steps("mix_both", 8);

        // All voices in phase after reset: the raw sum is +/-131072 and must clamp.
        for (int i = 0; i < NUM_VOICES; i++) begin
            vols[i]  = VOL_FULL;
            freqs[i] = F_LO;
        end
        do_reset();
        seq = '{-32768, 32767, 32767, -32768, 0, 0, 0, 0};
        queue_steps("saturate", 4);

        // Silent preroll walks voice 0 from 270 deg to phase 0, then hold it there.
        for (int i = 0; i < NUM_VOICES; i++) begin
            vols[i]  = '0;
            freqs[i] = '0;
        end
        freqs[0]       = F_PRE;
        filter_enabled = 1'b1;
        cutoff         = 3'd2;
        do_reset();
        repeat (6 * FRAME_LEN) @(posedge clk);
        @(negedge clk);
        check_value("filt_preroll", int'(out), 0);
        last_exp = 0;
        freqs[0] = '0;
        vols[0]  = VOL_FULL;

        y_model = 0;
        for (int t = 0; t < 8; t++) begin
            y_model = y_model + ((16384 - y_model) >>> 2);
            expected_q.push_back(y_model);
            filter_tick($sformatf("filt_k2[%0d]", t));
        end

        cutoff = 3'd0;
        expected_q.push_back(16384);
        filter_tick("filt_k0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
